// File: rtl/fetch_unit.sv
// Fetch stage: issues in-order instruction memory requests, buffers returned
// words in a small FIFO and presents one scalar or vector instruction per cycle.
module fetch_unit #(
  parameter int                N        = 24,
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [N-1:0]      imem_rdata,
  output logic [N-1:0]      InstrF,
  output logic [N-1:0]      InstrF_vector,
  output logic [ADDR_W-1:0] PCF,
  output logic              validF
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] r_req_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [CNT_W-1:0]  r_inflight;
  logic [CNT_W-1:0]  r_drop_cnt;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [N-1:0]      r_fifo_word [DEPTH];
  logic [ADDR_W-1:0] r_fifo_pc   [DEPTH];

  logic [CNT_W:0]    w_occupancy;
  logic              w_req;
  logic              w_accept;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [CNT_W-1:0]  w_rvalid_cnt;
  logic [CNT_W-1:0]  w_accept_cnt;
  logic [N-1:0]      w_head_word;
  logic [ADDR_W-1:0] w_head_pc;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Request handshake: a request transfers on a cycle where imem_req and
  // imem_ready are both high; imem_addr is stable while imem_req is held.
  assign w_occupancy  = {1'b0, r_inflight} + {1'b0, r_count};
  assign w_req        = !rst && !branch_taken && (w_occupancy < (CNT_W + 1)'(DEPTH));
  assign w_accept     = w_req && imem_ready;
  assign w_rvalid_cnt = CNT_W'(imem_rvalid);
  assign w_accept_cnt = CNT_W'(w_accept);
  assign w_drop       = imem_rvalid && (r_drop_cnt != '0);
  assign w_push       = imem_rvalid && (r_drop_cnt == '0) && !branch_taken;
  assign w_valid      = (r_count != '0) && !branch_taken;
  assign w_pop        = w_valid && !stallF;
  assign w_head_word  = r_fifo_word[r_rd_ptr];
  assign w_head_pc    = r_fifo_pc[r_rd_ptr];

  assign imem_req      = w_req;
  assign imem_addr     = r_req_pc;
  assign validF        = w_valid;
  assign PCF           = w_valid ? w_head_pc : '0;
  assign InstrF        = (w_valid && !w_head_word[N-1]) ? w_head_word : '0;
  assign InstrF_vector = (w_valid &&  w_head_word[N-1]) ? w_head_word : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pc   <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (branch_taken) begin
      // Every word still outstanding belongs to the old path and is discarded.
      r_req_pc   <= branch_target;
      r_resp_pc  <= branch_target;
      r_inflight <= r_inflight - w_rvalid_cnt;
      r_drop_cnt <= r_inflight - w_rvalid_cnt;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if (w_accept) begin
        r_req_pc <= r_req_pc + ADDR_W'(1);
      end
      r_inflight <= r_inflight + w_accept_cnt - w_rvalid_cnt;
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
      if (w_push) begin
        r_wr_ptr  <= next_ptr(r_wr_ptr);
        r_resp_pc <= r_resp_pc + ADDR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when r_count says they exist.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_word[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: variable-latency in-order memory model plus a
// program-order reference of which {pc, word} pairs must be presented.
module tb_fetch_unit;

  localparam int N        = 24;
  localparam int ADDR_W   = 32;
  localparam int DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam int W        = ADDR_W + N;

  logic              clk = 1'b0;
  logic              rst;
  logic              stallF;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic              imem_rvalid;
  logic [N-1:0]      imem_rdata;
  logic [N-1:0]      InstrF;
  logic [N-1:0]      InstrF_vector;
  logic [ADDR_W-1:0] PCF;
  logic              validF;

  fetch_unit #(.N(N), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrF(InstrF), .InstrF_vector(InstrF_vector), .PCF(PCF), .validF(validF)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mem_req_t;

  logic [N-1:0] mem_arr [256];
  mem_req_t     mem_q[$];
  logic [W-1:0] exp_q[$];   // accepted-but-not-presented {pc, word}, current path only
  logic [W-1:0] obs_q[$];   // what the DUT actually presented and handed on
  logic [31:0]  exp_addr;
  int           cur_epoch;
  int           cyc;
  int           lat_min;
  int           lat_max;
  int           checks;
  int           failures;
  logic         last_valid;
  logic         last_req;
  logic [31:0]  last_addr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int buffered_cnt();
    int cur_n = 0;
    foreach (mem_q[i]) if (mem_q[i].epoch == cur_epoch) cur_n++;
    return exp_q.size() - cur_n;
  endfunction

  // driver + reference model for one clock cycle
  task automatic step(input logic stall_i, input logic br_i, input logic [31:0] tgt_i,
                      input logic rdy_i, input logic rst_i);
    logic         rv;
    logic         e_req;
    logic         e_valid;
    logic [W-1:0] head;
    int           buffered;
    int           due;
    @(negedge clk);
    rv = !rst_i && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rst           = rst_i;
    stallF        = stall_i;
    branch_taken  = br_i;
    branch_target = tgt_i;
    imem_ready    = rdy_i;
    imem_rvalid   = rv;
    imem_rdata    = rv ? mem_arr[mem_q[0].addr[7:0]] : N'($urandom);
    #1;
    last_valid = validF;
    last_req   = imem_req;
    last_addr  = imem_addr;
    buffered   = buffered_cnt();
    e_req      = 1'b0;
    if (rst_i) begin
      check("req_in_rst", 64'(imem_req), 64'(0));
    end else begin
      e_req = !br_i && (mem_q.size() + buffered < DEPTH);
      check("imem_req", 64'(imem_req), 64'(e_req));
      if (e_req) check("imem_addr", 64'(imem_addr), 64'(exp_addr));
      e_valid = (buffered > 0) && !br_i;
      head    = e_valid ? exp_q[0] : '0;
      check("validF", 64'(validF), 64'(e_valid));
      check("PCF", 64'(PCF), 64'(head[W-1:N]));
      check("InstrF", 64'(InstrF), 64'(head[N-1] ? 24'h0 : head[N-1:0]));
      check("InstrF_vector", 64'(InstrF_vector), 64'(head[N-1] ? head[N-1:0] : 24'h0));
      if (validF && !stall_i) obs_q.push_back({PCF, InstrF | InstrF_vector});
      if (e_valid && !stall_i) void'(exp_q.pop_front());
    end
    if (rst_i) begin
      mem_q.delete();
      exp_q.delete();
      exp_addr = RESET_PC;
      cur_epoch++;
    end else begin
      if (rv) void'(mem_q.pop_front());
      if (br_i) begin
        exp_q.delete();
        cur_epoch++;
        exp_addr = tgt_i;
      end else if (e_req && rdy_i) begin
        due = cyc + $urandom_range(lat_max, lat_min);
        if (mem_q.size() > 0 && due <= mem_q[$].due) due = mem_q[$].due + 1;
        mem_q.push_back('{exp_addr, due, cur_epoch});
        exp_q.push_back({exp_addr, mem_arr[exp_addr[7:0]]});
        exp_addr = exp_addr + 32'd1;
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    logic done;
    checks = 0; failures = 0; cyc = 0; cur_epoch = 0;
    exp_addr = RESET_PC; lat_min = 1; lat_max = 1;
    rst = 1'b1; stallF = 1'b0; branch_taken = 1'b0; branch_target = '0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    for (int i = 0; i < 256; i++) mem_arr[i] = N'($urandom);
    mem_arr[0] = 24'h000011; mem_arr[1] = 24'h000022;
    mem_arr[2] = 24'h800005; mem_arr[3] = 24'h000007;

    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);

    // in-order fetch at 1-cycle latency, scalar/vector split
    obs_q.delete();
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    check("first_obs_count", 64'(obs_q.size() >= 4), 64'(1));
    if (obs_q.size() >= 4) begin
      check("obs0", 64'(obs_q[0]), {8'h0, 32'h0, 24'h000011});
      check("obs1", 64'(obs_q[1]), {8'h0, 32'h1, 24'h000022});
      check("obs2", 64'(obs_q[2]), {8'h0, 32'h2, 24'h800005});
      check("obs3", 64'(obs_q[3]), {8'h0, 32'h3, 24'h000007});
    end

    // stall for three cycles, then release
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
    check("req_dropped_in_stall", 64'(last_req), 64'(0));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

    // two requests in flight at 3-cycle latency, then redirect to 0x40
    lat_min = 3; lat_max = 3;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (mem_q.size() == 2 && exp_q.size() == 2) done = 1'b1;
      else step(0, 0, 0, 1, 0);
    end
    check("wait_two_inflight", 64'(done), 64'(1));
    step(0, 1, 32'h40, 1, 0);
    check("no_valid_on_redirect", 64'(last_valid), 64'(0));
    obs_q.delete();
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
    check("redirect_first_pc", 64'(obs_q.size() > 0 ? obs_q[0][W-1:N] : 32'hFFFF_FFFF), 64'(32'h40));

    // redirect coinciding with a response and a stall
    lat_min = 2; lat_max = 2;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) done = 1'b1;
      else step(0, 0, 0, 1, 0);
    end
    check("wait_rvalid", 64'(done), 64'(1));
    step(1, 1, 32'h80, 1, 0);
    step(1, 0, 0, 1, 0);
    check("empty_after_redirect", 64'(last_valid), 64'(0));
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

    // reset while the FIFO is full
    lat_min = 1; lat_max = 1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (buffered_cnt() == DEPTH) done = 1'b1;
      else step(1, 0, 0, 1, 0);
    end
    check("wait_fifo_full", 64'(done), 64'(1));
    step(1, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    check("rst_valid_clear", 64'(last_valid), 64'(0));
    check("rst_addr", 64'(last_addr), 64'(RESET_PC));

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        lat_min = $urandom_range(3, 1);
        lat_max = lat_min + $urandom_range(3, 0);
      end
      step($urandom_range(2, 0) == 0,
           $urandom_range(29, 0) == 0,
           $urandom,
           $urandom_range(3, 0) != 0,
           $urandom_range(199, 0) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
